// File: rtl/pc_sequencer_if.sv
// Bus between the fetch-stage sequencer and the pipeline control it drives.
// The master side feeds PC and hazard status in; the slave side is the sequencer.
interface pc_sequencer_if;
  logic [31:0] PCCur;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        LoadUseHazard;
  logic        MemBusy;
  logic        Halt;
  logic [31:0] PCNext;
  logic        PCStall;
  logic        IFIDStall;
  logic        IFIDFlush;
  logic [7:0]  StallCycles;
  logic        StallTimeout;
  logic        Halted;

  modport master (
    output PCCur, BranchTaken, BranchTarget, LoadUseHazard, MemBusy, Halt,
    input  PCNext, PCStall, IFIDStall, IFIDFlush, StallCycles, StallTimeout, Halted
  );

  modport slave (
    input  PCCur, BranchTaken, BranchTarget, LoadUseHazard, MemBusy, Halt,
    output PCNext, PCStall, IFIDStall, IFIDFlush, StallCycles, StallTimeout, Halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: chooses the fetch address and drives the PC/IF-ID stall and flush
// controls from branch, halt and hazard events, with a consecutive-stall watchdog.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_EXTRA  = 1,
  parameter int unsigned STALL_LIMIT  = 64
) (
  input logic          clk,
  input logic          Reset,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_EXTRA);
  localparam logic [7:0] LIMIT      = 8'(STALL_LIMIT);

  typedef enum logic [2:0] {BOOT, RUN, STALL, REDIRECT, HALTED} state_t;

  state_t      state, state_next;
  logic [1:0]  redir_cnt, redir_cnt_next;
  logic [31:0] pc_hold, pc_plus4, target_aligned, reset_aligned;
  logic [31:0] pc_next;
  logic        pc_stall, ifid_stall, ifid_flush;
  logic [7:0]  stall_cycles, stall_cycles_next;
  logic        stall_timeout, halted;
  logic        hazard;

  // Every fetch address is word aligned, so the low two bits are forced to zero everywhere.
  assign pc_hold        = {bus.PCCur[31:2], 2'b00};
  assign pc_plus4       = {bus.PCCur[31:2] + 30'd1, 2'b00};
  assign target_aligned = {bus.BranchTarget[31:2], 2'b00};
  assign reset_aligned  = {RESET_VECTOR[31:2], 2'b00};
  assign hazard         = bus.MemBusy | bus.LoadUseHazard;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= BOOT;
      redir_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      redir_cnt <= redir_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    redir_cnt_next = redir_cnt;
    case (state)
      BOOT: state_next = RUN;
      RUN, STALL: begin
        if (bus.BranchTaken) begin
          redir_cnt_next = FLUSH_LOAD;
          state_next     = (FLUSH_LOAD == 2'd0) ? RUN : REDIRECT;
        end else if (bus.Halt) begin
          state_next = HALTED;
        end else if (hazard) begin
          state_next = STALL;
        end else begin
          state_next = RUN;
        end
      end
      REDIRECT: begin
        // The squash window only counts down on cycles that actually fetch.
        if (!bus.MemBusy) begin
          if (redir_cnt != 2'd0) redir_cnt_next = redir_cnt - 2'd1;
          if (redir_cnt <= 2'd1) state_next = RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_next    = pc_hold;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    if (Reset) begin
      pc_next    = reset_aligned;
      ifid_flush = 1'b1;
    end else begin
      case (state)
        BOOT: begin
          pc_next    = reset_aligned;
          ifid_flush = 1'b1;
        end
        RUN, STALL: begin
          if (bus.BranchTaken) begin
            pc_next    = target_aligned;
            ifid_flush = 1'b1;
          end else if (bus.Halt) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
          end else if (hazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
          end else begin
            pc_next = pc_plus4;
          end
        end
        REDIRECT: begin
          ifid_flush = 1'b1;
          if (bus.MemBusy) pc_stall = 1'b1;
          else             pc_next  = pc_plus4;
        end
        HALTED: begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
        end
        default: begin
          pc_next    = reset_aligned;
          ifid_flush = 1'b1;
        end
      endcase
    end
  end

  // Halted cycles neither count nor clear the stall run; the watchdog flag is sticky.
  always_comb begin
    stall_cycles_next = stall_cycles;
    if (!pc_stall)
      stall_cycles_next = 8'd0;
    else if (state != HALTED && stall_cycles != 8'hFF)
      stall_cycles_next = stall_cycles + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      stall_cycles  <= 8'd0;
      stall_timeout <= 1'b0;
      halted        <= 1'b0;
    end else begin
      stall_cycles <= stall_cycles_next;
      if (stall_cycles_next == LIMIT) stall_timeout <= 1'b1;
      halted <= (state_next == HALTED);
    end
  end

  assign bus.PCNext       = pc_next;
  assign bus.PCStall      = pc_stall;
  assign bus.IFIDStall    = ifid_stall;
  assign bus.IFIDFlush    = ifid_flush;
  assign bus.StallCycles  = stall_cycles;
  assign bus.StallTimeout = stall_timeout;
  assign bus.Halted       = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table for boot, branch, priority,
// wrap, halt and reset corners, followed by hand-written watchdog and halt-hold sequences.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_EXTRA (1),
    .STALL_LIMIT (64)
  ) dut (
    .clk  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pccur;
    logic        bt;
    logic [31:0] tgt;
    logic        luh;
    logic        mb;
    logic        halt;
    logic [31:0] pcnext;
    logic        pcstall;
    logic        ifidstall;
    logic        ifidflush;
    logic [7:0]  sc;
    logic        halted;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic r, logic [31:0] pc, logic b, logic [31:0] t, logic l,
                              logic m, logic h, logic [31:0] en, logic es, logic eis,
                              logic ef, logic [7:0] esc, logic eh);
    vec_t v;
    v.rst = r; v.pccur = pc; v.bt = b; v.tgt = t; v.luh = l; v.mb = m; v.halt = h;
    v.pcnext = en; v.pcstall = es; v.ifidstall = eis; v.ifidflush = ef;
    v.sc = esc; v.halted = eh;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic b,
                               input logic [31:0] t, input logic l, input logic m,
                               input logic h);
    rst                = r;
    bus.PCCur          = pc;
    bus.BranchTaken    = b;
    bus.BranchTarget   = t;
    bus.LoadUseHazard  = l;
    bus.MemBusy        = m;
    bus.Halt           = h;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.PCCur = '0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus.LoadUseHazard = 1'b0; bus.MemBusy = 1'b0; bus.Halt = 1'b0;

    //                r  PCCur         bt tgt          luh mb hlt  PCNext       stl ist fl sc  hlt
    vecs[0]  = mk(1, 32'h0000_1234, 1, 32'h500, 0, 1, 1, 32'h0,        0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 32'h0000_0000, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 32'h0000_0000, 0, 32'h0,   0, 1, 1, 32'h0,        0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 32'h0000_0000, 0, 32'h0,   0, 0, 0, 32'h4,        0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 32'h0000_0004, 0, 32'h0,   0, 0, 0, 32'h8,        0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 32'h0000_0008, 0, 32'h0,   0, 0, 0, 32'hC,        0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 32'h0000_0020, 1, 32'h103, 0, 0, 0, 32'h100,      0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 32'h0000_0100, 1, 32'h999, 1, 0, 1, 32'h104,      0, 0, 1, 0, 0);
    vecs[8]  = mk(0, 32'h0000_0104, 0, 32'h0,   0, 0, 0, 32'h108,      0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 32'h0000_0108, 0, 32'h0,   1, 0, 0, 32'h108,      1, 1, 0, 1, 0);
    vecs[10] = mk(0, 32'h0000_0108, 0, 32'h0,   0, 1, 0, 32'h108,      1, 1, 0, 2, 0);
    vecs[11] = mk(0, 32'h0000_0108, 0, 32'h0,   0, 0, 0, 32'h10C,      0, 0, 0, 0, 0);
    vecs[12] = mk(0, 32'h0000_0040, 1, 32'h80,  0, 1, 1, 32'h80,       0, 0, 1, 0, 0);
    vecs[13] = mk(0, 32'h0000_0080, 0, 32'h0,   0, 1, 0, 32'h80,       1, 0, 1, 1, 0);
    vecs[14] = mk(0, 32'h0000_0080, 0, 32'h0,   0, 0, 0, 32'h84,       0, 0, 1, 0, 0);
    vecs[15] = mk(0, 32'hFFFF_FFFC, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    vecs[16] = mk(0, 32'h0000_0000, 0, 32'h0,   0, 1, 0, 32'h0,        1, 1, 0, 1, 0);
    vecs[17] = mk(0, 32'h0000_0000, 1, 32'h202, 0, 1, 0, 32'h200,      0, 0, 1, 0, 0);
    vecs[18] = mk(0, 32'h0000_0200, 0, 32'h0,   0, 0, 0, 32'h204,      0, 0, 1, 0, 0);
    vecs[19] = mk(0, 32'h0000_0204, 0, 32'h0,   1, 0, 1, 32'h204,      1, 0, 1, 1, 1);
    vecs[20] = mk(0, 32'h0000_0204, 1, 32'h300, 0, 0, 0, 32'h204,      1, 0, 1, 1, 1);
    vecs[21] = mk(0, 32'h0000_0204, 0, 32'h0,   0, 0, 0, 32'h204,      1, 0, 1, 1, 1);
    vecs[22] = mk(1, 32'h0000_0204, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[23] = mk(0, 32'h0000_0000, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[24] = mk(0, 32'h0000_0000, 1, 32'h40,  0, 0, 0, 32'h40,       0, 0, 1, 0, 0);
    vecs[25] = mk(1, 32'h0000_0040, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[26] = mk(0, 32'h0000_0000, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[27] = mk(0, 32'h0000_0000, 0, 32'h0,   0, 0, 0, 32'h4,        0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pccur, vecs[i].bt, vecs[i].tgt,
                    vecs[i].luh, vecs[i].mb, vecs[i].halt);
      checkOutput($sformatf("v%0d PCNext", i),    bus.PCNext,            vecs[i].pcnext);
      checkOutput($sformatf("v%0d PCStall", i),   32'(bus.PCStall),      32'(vecs[i].pcstall));
      checkOutput($sformatf("v%0d IFIDStall", i), 32'(bus.IFIDStall),    32'(vecs[i].ifidstall));
      checkOutput($sformatf("v%0d IFIDFlush", i), 32'(bus.IFIDFlush),    32'(vecs[i].ifidflush));
      afterEdge();
      checkOutput($sformatf("v%0d StallCycles", i),  32'(bus.StallCycles),  32'(vecs[i].sc));
      checkOutput($sformatf("v%0d Halted", i),       32'(bus.Halted),       32'(vecs[i].halted));
      checkOutput($sformatf("v%0d StallTimeout", i), 32'(bus.StallTimeout), 32'd0);
      @(negedge clk);
    end

    // Long MemBusy run: PC frozen, watchdog trips at 64, counter saturates at 255.
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(0, 32'h10, 0, 32'h0, 0, 1, 0);
      checkOutput($sformatf("wd%0d PCNext", k),  bus.PCNext,        32'h10);
      checkOutput($sformatf("wd%0d PCStall", k), 32'(bus.PCStall),  32'd1);
      afterEdge();
      checkOutput($sformatf("wd%0d StallCycles", k), 32'(bus.StallCycles),
                  (k > 255) ? 32'd255 : 32'(k));
      checkOutput($sformatf("wd%0d StallTimeout", k), 32'(bus.StallTimeout),
                  (k >= 64) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    applyStimulus(0, 32'h10, 0, 32'h0, 0, 0, 0);
    checkOutput("wd_release PCNext",  bus.PCNext,       32'h14);
    checkOutput("wd_release PCStall", 32'(bus.PCStall), 32'd0);
    afterEdge();
    checkOutput("wd_release StallCycles",  32'(bus.StallCycles),  32'd0);
    checkOutput("wd_release StallTimeout", 32'(bus.StallTimeout), 32'd1);
    @(negedge clk);

    applyStimulus(0, 32'h14, 0, 32'h0, 0, 0, 1);
    checkOutput("halt_enter PCStall",   32'(bus.PCStall),   32'd1);
    checkOutput("halt_enter IFIDFlush", 32'(bus.IFIDFlush), 32'd1);
    afterEdge();
    checkOutput("halt_enter Halted", 32'(bus.Halted), 32'd1);
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 32'h14, k[0], 32'h700, 0, 0, 0);
      checkOutput($sformatf("halt%0d PCNext", k),    bus.PCNext,         32'h14);
      checkOutput($sformatf("halt%0d PCStall", k),   32'(bus.PCStall),   32'd1);
      checkOutput($sformatf("halt%0d IFIDFlush", k), 32'(bus.IFIDFlush), 32'd1);
      afterEdge();
      checkOutput($sformatf("halt%0d Halted", k),       32'(bus.Halted),       32'd1);
      checkOutput($sformatf("halt%0d StallTimeout", k), 32'(bus.StallTimeout), 32'd1);
      @(negedge clk);
    end

    applyStimulus(1, 32'h14, 1, 32'h700, 1, 1, 1);
    checkOutput("rst_halt PCNext",    bus.PCNext,         32'h0);
    checkOutput("rst_halt PCStall",   32'(bus.PCStall),   32'd0);
    checkOutput("rst_halt IFIDStall", 32'(bus.IFIDStall), 32'd0);
    checkOutput("rst_halt IFIDFlush", 32'(bus.IFIDFlush), 32'd1);
    afterEdge();
    checkOutput("rst_halt Halted",       32'(bus.Halted),       32'd0);
    checkOutput("rst_halt StallTimeout", 32'(bus.StallTimeout), 32'd0);
    checkOutput("rst_halt StallCycles",  32'(bus.StallCycles),  32'd0);
    @(negedge clk);

    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0);
    checkOutput("boot PCNext",    bus.PCNext,         32'h0);
    checkOutput("boot IFIDFlush", 32'(bus.IFIDFlush), 32'd1);
    afterEdge();
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0);
    checkOutput("run PCNext",    bus.PCNext,         32'h4);
    checkOutput("run IFIDFlush", 32'(bus.IFIDFlush), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FLUSH_EXTRA, default 1, legal range 0..3: extra squash cycles after a taken branch.
REQ-003 Parameter STALL_LIMIT, default 64, legal range 1..255: consecutive-stall count that raises StallTimeout.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port PCCur, input, 32: current PC from the PC register.
REQ-008 Port BranchTaken, input, 1: EX stage resolved a taken branch or jump.
REQ-009 Port BranchTarget, input, 32: redirect address, valid when BranchTaken=1.
REQ-010 Port LoadUseHazard, input, 1: decode needs a one-slot bubble.
REQ-011 Port MemBusy, input, 1: instruction memory cannot accept a fetch this cycle.
REQ-012 Port Halt, input, 1: halt instruction reached decode.
REQ-013 Port PCNext, output, 32: next-PC value driven to the PC register.
REQ-014 Port PCStall, output, 1: PC register enable; 1 holds the PC.
REQ-015 Port IFIDStall, output, 1: hold the IF/ID register.
REQ-016 Port IFIDFlush, output, 1: load a bubble into IF/ID.
REQ-017 Port StallCycles, output, 8: count of consecutive stalled cycles.
REQ-018 Port StallTimeout, output, 1: sticky watchdog flag.
REQ-019 Port Halted, output, 1: core is halted.

Function
REQ-020 Output timing SHALL be as follows.
- PCNext, PCStall, IFIDStall and IFIDFlush SHALL be combinational from the current state and inputs.
- The PC register and IF/ID capture these outputs at the next rising edge.
- StallCycles, StallTimeout and Halted SHALL be registered.
REQ-021 The state machine SHALL have states BOOT, RUN, STALL, REDIRECT and HALTED.
REQ-022 PCNext[1:0] SHALL always be 2'b00; BranchTarget[1:0] is ignored.
REQ-023 PCCur+4 SHALL wrap modulo 2^32, so PCCur=32'hFFFF_FFFC gives PCNext=32'h0000_0000.
REQ-024 BOOT SHALL drive:
- PCNext=RESET_VECTOR, PCStall=0, IFIDFlush=1;
- next state RUN, regardless of any other input.
REQ-025 In RUN and STALL, events SHALL be handled in priority order BranchTaken > Halt > (MemBusy | LoadUseHazard) > advance.
REQ-026 When BranchTaken=1 in RUN or STALL, the block SHALL:
- drive PCNext=BranchTarget, PCStall=0, IFIDFlush=1, IFIDStall=0;
- load the redirect counter with FLUSH_EXTRA;
- go to REDIRECT, or to RUN if FLUSH_EXTRA=0.
REQ-027 When Halt=1 and BranchTaken=0, the block SHALL drive PCStall=1 and IFIDFlush=1, then go to HALTED.
REQ-028 When MemBusy or LoadUseHazard is 1 and BranchTaken=0 and Halt=0, the block SHALL:
- drive PCStall=1 and IFIDStall=1, with PCNext=PCCur;
- go to STALL.
REQ-029 When no event is present in RUN or STALL, the block SHALL drive PCNext=PCCur+4, PCStall=0, IFIDStall=0 and IFIDFlush=0, then go to RUN.
REQ-030 In REDIRECT the block SHALL:
- drive IFIDFlush=1 and ignore BranchTaken, Halt and LoadUseHazard;
- if MemBusy=1, drive PCStall=1 and hold the counter;
- otherwise drive PCNext=PCCur+4 and PCStall=0, then decrement the counter;
- go to RUN on the cycle the counter decrements from 1 to 0.
REQ-031 HALTED SHALL drive PCStall=1, IFIDFlush=1 and Halted=1, and SHALL hold until Reset.
REQ-032 StallCycles SHALL increment, saturating at 255, on every cycle with PCStall=1 outside HALTED; it SHALL clear to 0 on any cycle with PCStall=0.
REQ-033 StallTimeout SHALL set on the edge where StallCycles becomes equal to STALL_LIMIT, and SHALL remain set until Reset.

Reset
REQ-034 When Reset=1 at a rising edge, the next state SHALL be BOOT, the redirect counter 0, StallCycles 0, StallTimeout 0 and Halted 0.
REQ-035 While Reset=1, combinational outputs SHALL be PCNext=RESET_VECTOR, PCStall=0, IFIDStall=0 and IFIDFlush=1.
REQ-036 Reset asserted in any state, including mid-REDIRECT or HALTED, SHALL abandon the state in progress with no residual flush or stall.

Verification
REQ-037 Boot: Reset high for 2 cycles, then low -> the PC holds 0, then 4, 8, 12 on successive cycles; IFIDFlush=1 only in BOOT.
REQ-038 Branch: at PCCur=0x20, BranchTaken=1 and BranchTarget=0x103 with FLUSH_EXTRA=1 -> PCNext=0x100 with flush that cycle; next cycle PCNext=0x104 with flush; then 0x108 with no flush.
REQ-039 Priority: BranchTaken, Halt and MemBusy all high in RUN at PCCur=0x40 with BranchTarget=0x80 -> PCNext=0x80, PCStall=0, state REDIRECT, Halted stays 0.
REQ-040 Stall watchdog: MemBusy high for 70 cycles with STALL_LIMIT=64 -> PC frozen, StallCycles reaches 64 then 70, StallTimeout=1; after MemBusy drops, StallCycles=0 and StallTimeout stays 1.
REQ-041 Wrap and halt: PCCur=0xFFFF_FFFC with no event -> PCNext=0; then Halt=1 -> Halted=1 and PCStall=1 for 10 cycles despite BranchTaken pulses; Reset -> BOOT.
